instr_fetch_unit: RTL and testbench

// - Initiator side of the instruction-memory req/gnt interface.
// - Generates sequential fetch addresses from an internal PC.
// - Issues instr_req_o/instr_addr_o and captures instr_i on grant into a prefetch FIFO.
// - Hands buffered {addr, instr} pairs to the core over a valid/ready port; supports PC redirect (branch/jump) with flush.
// - Sits between the verification instruction memory and the core front-end in the darkriscv bench.

---
 rtl/instr_fetch_unit.sv | 132 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Sequential instruction fetch with a prefetch FIFO, a valid/ready hand-off to the core and redirect/flush.
// Optional macro FETCH_LIMIT_EN adds a HALT state once the PC reaches LIMIT_ADDR.
module instr_fetch_unit #(
    parameter int          DEPTH      = 4,
    parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000,
    parameter logic [31:0] LIMIT_ADDR = 32'h0000_0200
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     enable_i,
    output logic                     instr_req_o,
    output logic [31:0]              instr_addr_o,
    input  logic                     instr_gnt_i,
    input  logic [31:0]              instr_i,
    input  logic                     redirect_i,
    input  logic [31:0]              redirect_addr_i,
    output logic                     fetch_valid_o,
    output logic [31:0]              fetch_addr_o,
    output logic [31:0]              fetch_instr_o,
    input  logic                     fetch_ready_i,
    output logic [$clog2(DEPTH):0]   fifo_count_o,
    output logic                     done_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

`ifdef FETCH_LIMIT_EN
    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
`else
    typedef enum logic [1:0] {IDLE, RUN} state_t;
`endif

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] instr;
    } fetch_entry_t;

    state_t         state_q, state_d;
    logic [31:0]    pc_q;
    logic [CW-1:0]  count_q;
    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    fetch_entry_t   fifo_q [DEPTH];

    logic           full, push, pop, req;
    logic [31:0]    redir_pc;
    logic           unused_bits;

    assign redir_pc    = {redirect_addr_i[31:2], 2'b00};
    assign unused_bits = ^redirect_addr_i[1:0];
    assign full        = (count_q == CW'(DEPTH));

`ifdef FETCH_LIMIT_EN
    logic at_limit;
    assign at_limit = (pc_q >= LIMIT_ADDR);
    assign req      = (state_q == RUN) & ~full & ~redirect_i & ~at_limit;
`else
    logic unused_limit;
    assign unused_limit = ^LIMIT_ADDR;
    assign req          = (state_q == RUN) & ~full & ~redirect_i;
`endif

    assign push = req & instr_gnt_i;
    // A redirect flushes the FIFO, so a same-cycle pop must not also move the read pointer.
    assign pop  = fetch_valid_o & fetch_ready_i & ~redirect_i;

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (!redirect_i && enable_i) state_d = RUN;
            RUN: begin
`ifdef FETCH_LIMIT_EN
                if (!redirect_i && at_limit)                 state_d = HALT;
                else
`endif
                // An ungranted request keeps the unit in RUN even with enable dropped.
                if (!enable_i && !(req && !instr_gnt_i))      state_d = IDLE;
            end
`ifdef FETCH_LIMIT_EN
            HALT: if (redirect_i && (redir_pc < LIMIT_ADDR)) state_d = enable_i ? RUN : IDLE;
`endif
            default: state_d = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        instr_req_o   = req;
        instr_addr_o  = pc_q;
        fetch_valid_o = (count_q != '0);
        fetch_addr_o  = fifo_q[rd_ptr_q].addr;
        fetch_instr_o = fifo_q[rd_ptr_q].instr;
        fifo_count_o  = count_q;
`ifdef FETCH_LIMIT_EN
        done_o        = (state_q == HALT) && (count_q == '0);
`else
        done_o        = 1'b0;
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q     <= BOOT_ADDR;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (redirect_i) begin
            pc_q     <= redir_pc;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) begin
                pc_q     <= pc_q + 32'd4;
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    // Storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk_i) begin
        if (push) fifo_q[wr_ptr_q] <= '{addr: pc_q, instr: instr_i};
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: streaming, full FIFO, stalls, redirect, wrap, async reset.
// The limit section is compiled only when FETCH_LIMIT_EN is defined.
module tb_instr_fetch_unit;
    logic        clk_i = 1'b0;
    logic        rst_ni, enable_i, instr_req_o, instr_gnt_i, redirect_i;
    logic        fetch_valid_o, fetch_ready_i, done_o;
    logic [31:0] instr_addr_o, instr_i, redirect_addr_i, fetch_addr_o, fetch_instr_o;
    logic [2:0]  fifo_count_o;
    int          n_chk = 0, n_err = 0;

    instr_fetch_unit #(.DEPTH(4), .BOOT_ADDR(32'h0), .LIMIT_ADDR(32'h10)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i),
        .instr_req_o(instr_req_o), .instr_addr_o(instr_addr_o),
        .instr_gnt_i(instr_gnt_i), .instr_i(instr_i),
        .redirect_i(redirect_i), .redirect_addr_i(redirect_addr_i),
        .fetch_valid_o(fetch_valid_o), .fetch_addr_o(fetch_addr_o),
        .fetch_instr_o(fetch_instr_o), .fetch_ready_i(fetch_ready_i),
        .fifo_count_o(fifo_count_o), .done_o(done_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h0) ? 32'h0010_0093 : (32'hC0DE_0000 ^ a);
    endfunction

    assign instr_i = mem_word(instr_addr_o);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_ni = 1'b0; enable_i = 1'b0; instr_gnt_i = 1'b0; redirect_i = 1'b0;
        redirect_addr_i = '0; fetch_ready_i = 1'b0;
        #3;
        chk("rst_req",   32'(instr_req_o),   0);
        chk("rst_addr",  instr_addr_o,       32'h0);
        chk("rst_valid", 32'(fetch_valid_o), 0);
        chk("rst_count", 32'(fifo_count_o),  0);
        chk("rst_done",  32'(done_o),        0);

        // T1: streaming with grant and ready high
        tick(); tick();
        rst_ni = 1'b1; enable_i = 1'b1; instr_gnt_i = 1'b1; fetch_ready_i = 1'b1; #1;
        chk("t1_idle_req", 32'(instr_req_o), 0);
        tick(); #1;
        chk("t1_req0",   32'(instr_req_o),   1);
        chk("t1_addr0",  instr_addr_o,       32'h0);
        chk("t1_nvalid", 32'(fetch_valid_o), 0);
        tick(); #1;
        chk("t1_addr4",  instr_addr_o,       32'h4);
        chk("t1_valid",  32'(fetch_valid_o), 1);
        chk("t1_faddr0", fetch_addr_o,       32'h0);
        chk("t1_finstr", fetch_instr_o,      32'h0010_0093);
        tick(); #1;
        chk("t1_addr8",  instr_addr_o,       32'h8);
        chk("t1_faddr4", fetch_addr_o,       32'h4);
        chk("t1_finst4", fetch_instr_o,      32'hC0DE_0004);
        chk("t1_count",  32'(fifo_count_o),  1);

        // T2: fill FIFO with ready low
        redirect_i = 1'b1; redirect_addr_i = 32'h0; fetch_ready_i = 1'b0; #1;
        chk("t2_redir_req", 32'(instr_req_o), 0);
        tick(); redirect_i = 1'b0; #1;
        for (int i = 0; i < 4; i++) begin
            chk("t2_fill_req",  32'(instr_req_o), 1);
            chk("t2_fill_addr", instr_addr_o,     32'(4 * i));
            tick(); #1;
        end
        chk("t2_full_req",   32'(instr_req_o),  0);
        chk("t2_full_count", 32'(fifo_count_o), 4);
        fetch_ready_i = 1'b1; #1;
        chk("t2_head", fetch_addr_o, 32'h0);
        tick(); fetch_ready_i = 1'b0; instr_gnt_i = 1'b0; #1;
        chk("t2_count3", 32'(fifo_count_o), 3);
        chk("t2_req",    32'(instr_req_o),  1);
        chk("t2_addr10", instr_addr_o,      32'h10);
        chk("t2_head4",  fetch_addr_o,      32'h4);
        tick(); #1;
        chk("t2_pend_addr", instr_addr_o, 32'h10);

        // T4: redirect with same-cycle pop
        redirect_i = 1'b1; redirect_addr_i = 32'h43; fetch_ready_i = 1'b1; #1;
        chk("t4_req_drop", 32'(instr_req_o), 0);
        tick(); redirect_i = 1'b0; fetch_ready_i = 1'b0; #1;
        chk("t4_count", 32'(fifo_count_o),  0);
        chk("t4_valid", 32'(fetch_valid_o), 0);
        chk("t4_req",   32'(instr_req_o),   1);
        chk("t4_addr",  instr_addr_o,       32'h40);

        // T3: stalled request held while enable drops
        redirect_i = 1'b1; redirect_addr_i = 32'h8; #1;
        tick(); redirect_i = 1'b0; #1;
        chk("t3_c1_req",  32'(instr_req_o), 1);
        chk("t3_c1_addr", instr_addr_o,     32'h8);
        tick(); enable_i = 1'b0; #1;
        chk("t3_c2_req",  32'(instr_req_o), 1);
        chk("t3_c2_addr", instr_addr_o,     32'h8);
        tick(); #1;
        chk("t3_c3_req",  32'(instr_req_o), 1);
        chk("t3_c3_addr", instr_addr_o,     32'h8);
        tick(); instr_gnt_i = 1'b1; #1;
        chk("t3_gnt_req", 32'(instr_req_o), 1);
        tick(); instr_gnt_i = 1'b0; #1;
        chk("t3_idle_req", 32'(instr_req_o),  0);
        chk("t3_count",    32'(fifo_count_o), 1);
        chk("t3_faddr",    fetch_addr_o,      32'h8);
        chk("t3_finstr",   fetch_instr_o,     32'hC0DE_0008);
        tick(); tick(); #1;
        chk("t3_keep_count", 32'(fifo_count_o), 1);
        chk("t3_keep_req",   32'(instr_req_o),  0);

        // PC wrap at top of address space
        redirect_i = 1'b1; redirect_addr_i = 32'hFFFF_FFFF; #1;
        tick(); redirect_i = 1'b0; enable_i = 1'b1; instr_gnt_i = 1'b1; fetch_ready_i = 1'b1; #1;
        chk("wr_idle_req", 32'(instr_req_o),  0);
        chk("wr_flush",    32'(fifo_count_o), 0);
        tick(); #1;
        chk("wr_addr_top", instr_addr_o, 32'hFFFF_FFFC);
        tick(); instr_gnt_i = 1'b0; #1;
        chk("wr_addr_0", instr_addr_o,      32'h0);
        chk("wr_req",    32'(instr_req_o),  1);
        chk("wr_faddr",  fetch_addr_o,      32'hFFFF_FFFC);

        // T6: async reset during a pending request
        #2 rst_ni = 1'b0; #1;
        chk("t6_req",   32'(instr_req_o),   0);
        chk("t6_valid", 32'(fetch_valid_o), 0);
        chk("t6_count", 32'(fifo_count_o),  0);
        chk("t6_addr",  instr_addr_o,       32'h0);
        tick(); rst_ni = 1'b1; instr_gnt_i = 1'b1; fetch_ready_i = 1'b1; #1;
        chk("t6_idle_req", 32'(instr_req_o), 0);
        tick(); #1;
        chk("t6_req_boot", 32'(instr_req_o), 1);
        chk("t6_addr_boot", instr_addr_o,    32'h0);

`ifdef FETCH_LIMIT_EN
        // T5: fetch stops at LIMIT_ADDR, done after drain, redirect restarts
        for (int i = 1; i < 4; i++) begin
            tick(); #1;
            chk("t5_addr", instr_addr_o, 32'(4 * i));
        end
        tick(); #1;
        chk("t5_limit_req", 32'(instr_req_o), 0);
        chk("t5_nodone",    32'(done_o),      0);
        tick(); #1;
        chk("t5_done",   32'(done_o),        1);
        chk("t5_empty",  32'(fetch_valid_o), 0);
        redirect_i = 1'b1; redirect_addr_i = 32'h0; #1;
        tick(); redirect_i = 1'b0; #1;
        chk("t5_redo_done", 32'(done_o),      0);
        chk("t5_redo_req",  32'(instr_req_o), 1);
        chk("t5_redo_addr", instr_addr_o,     32'h0);
`else
        tick(); tick(); #1;
        chk("nolimit_done", 32'(done_o),      0);
        chk("nolimit_req",  32'(instr_req_o), 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
